// File: rtl/ball_motion_engine.sv
// ---------------------------------------------------------------------------
// ball_motion_engine
//
// Moves one ball over a rectangular quidditch field at a programmable tick
// rate. On every motion tick in PLAY it checks for hoop entry, reflects off
// the field walls and off N_PLAYERS circular players, then advances the ball
// by its (possibly updated) velocity. A serve/score state machine holds the
// ball at the serve point before play and freezes it in the hoop after a
// score.
//
// Optional feature macro: SPEEDUP_EN
//   defined   : every applied player reflection adds 1 to |vx| and |vy|,
//               saturating at MAX_SPEED; speed drops back to BASE_SPEED on
//               every serve.
//   undefined : speed stays at BASE_SPEED; MAX_SPEED has no effect.
//
// Ports
//   clk               in   system clock
//   rst_n             in   asynchronous active-low reset
//   game_initiated    in   level, starts play from IDLE
//   game_over         in   level, forces IDLE (beats game_initiated)
//   player_x/player_y in   packed unsigned player centres, 10 bits each,
//                          player i at bits [10i+9:10i]
//   x_position/y_pos  out  signed ball centre
//   ball_state        out  0 IDLE, 1 SERVE, 2 PLAY, 3 SCORED
//   hit_player        out  one-cycle pulse per player that deflected the ball
//   blue_score_pulse  out  one-cycle pulse, ball entered the top (red) goal
//   red_score_pulse   out  one-cycle pulse, ball entered the bottom (blue) goal
// ---------------------------------------------------------------------------
module ball_motion_engine #(
  parameter int POS_W         = 11,
  parameter int VEL_W         = 5,
  parameter int N_PLAYERS     = 4,
  parameter int PLAYER_RADIUS = 28,
  parameter int BALL_RADIUS   = 8,
  parameter int GOAL_RADIUS   = 40,
  parameter int TICK_DIV      = 500000,
  parameter int FIELD_LEFT    = 150,
  parameter int FIELD_RIGHT   = 660,
  parameter int FIELD_TOP     = 36,
  parameter int FIELD_BOTTOM  = 510,
  parameter int SERVE_X       = 400,
  parameter int SERVE_Y       = 275,
  parameter int GOAL_TOP_Y    = 100,
  parameter int GOAL_BOT_Y    = 450,
  parameter int GOAL_XC       = 400,
  parameter int GOAL_DX       = 100,
  parameter int BASE_SPEED    = 2,
  parameter int SERVE_DELAY   = 60,
  parameter int SCORE_HOLD    = 30,
  parameter int MAX_SPEED     = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          game_initiated,
  input  logic                          game_over,
  input  logic [N_PLAYERS*10-1:0]       player_x,
  input  logic [N_PLAYERS*10-1:0]       player_y,
  output logic signed [POS_W-1:0]       x_position,
  output logic signed [POS_W-1:0]       y_position,
  output logic [1:0]                    ball_state,
  output logic [N_PLAYERS-1:0]          hit_player,
  output logic                          blue_score_pulse,
  output logic                          red_score_pulse
);

  // Differences carry one extra bit so any signed position minus any 10-bit
  // player/hoop coordinate fits; squares are taken on the magnitude.
  localparam int D_W    = POS_W + 1;
  localparam int SQ_W   = 2 * POS_W + 2;
  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int PH_MAX = (SERVE_DELAY > SCORE_HOLD) ? SERVE_DELAY : SCORE_HOLD;
  localparam int PH_W   = $clog2(PH_MAX + 1);

`ifdef SPEEDUP_EN
  localparam int SPEED_STEP = 1;
`else
  localparam int SPEED_STEP = 0;
`endif
  // Ceiling never sits below the serve speed, so with a zero step it is inert.
  localparam int SPEED_CEIL = (MAX_SPEED < BASE_SPEED) ? BASE_SPEED : MAX_SPEED;

  localparam logic signed [VEL_W-1:0] V_BASE = VEL_W'(BASE_SPEED);
  localparam logic signed [VEL_W-1:0] V_STEP = VEL_W'(SPEED_STEP);
  localparam logic signed [VEL_W-1:0] V_CEIL = VEL_W'(SPEED_CEIL);

  localparam logic signed [POS_W-1:0] SX   = POS_W'(SERVE_X);
  localparam logic signed [POS_W-1:0] SY   = POS_W'(SERVE_Y);
  localparam logic signed [POS_W-1:0] X_LO = POS_W'(FIELD_LEFT + BALL_RADIUS);
  localparam logic signed [POS_W-1:0] X_HI = POS_W'(FIELD_RIGHT - BALL_RADIUS);
  localparam logic signed [POS_W-1:0] Y_LO = POS_W'(FIELD_TOP + BALL_RADIUS);
  localparam logic signed [POS_W-1:0] Y_HI = POS_W'(FIELD_BOTTOM - BALL_RADIUS);
  localparam logic signed [POS_W-1:0] X_LO_IN = POS_W'(FIELD_LEFT + BALL_RADIUS + 1);
  localparam logic signed [POS_W-1:0] X_HI_IN = POS_W'(FIELD_RIGHT - BALL_RADIUS - 1);
  localparam logic signed [POS_W-1:0] Y_LO_IN = POS_W'(FIELD_TOP + BALL_RADIUS + 1);
  localparam logic signed [POS_W-1:0] Y_HI_IN = POS_W'(FIELD_BOTTOM - BALL_RADIUS - 1);

  localparam logic [SQ_W-1:0] GOAL_R2 =
    SQ_W'((GOAL_RADIUS - BALL_RADIUS) * (GOAL_RADIUS - BALL_RADIUS));
  localparam logic [SQ_W-1:0] CONTACT_R2 =
    SQ_W'((PLAYER_RADIUS + BALL_RADIUS) * (PLAYER_RADIUS + BALL_RADIUS));

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_SCORED = 2'd3
  } state_t;

  function automatic logic signed [D_W-1:0] sext_pos(input logic signed [POS_W-1:0] p);
    return {p[POS_W-1], p};
  endfunction

  function automatic logic signed [D_W-1:0] zext_pix(input logic [9:0] p);
    return $signed({{(D_W-10){1'b0}}, p});
  endfunction

  function automatic logic [D_W-1:0] mag_d(input logic signed [D_W-1:0] d);
    return d[D_W-1] ? $unsigned(-d) : $unsigned(d);
  endfunction

  function automatic logic [SQ_W-1:0] sq(input logic signed [D_W-1:0] d);
    logic [SQ_W-1:0] m;
    m = {{(SQ_W-D_W){1'b0}}, mag_d(d)};
    return m * m;
  endfunction

  function automatic logic signed [VEL_W-1:0] vmag(input logic signed [VEL_W-1:0] v);
    return v[VEL_W-1] ? -v : v;
  endfunction

  // Add the speed step to the magnitude, saturate, keep the sign.
  function automatic logic signed [VEL_W-1:0] vbump(input logic signed [VEL_W-1:0] v);
    logic signed [VEL_W-1:0] m;
    m = vmag(v) + V_STEP;
    if (m > V_CEIL) m = V_CEIL;
    return v[VEL_W-1] ? -m : m;
  endfunction

  function automatic logic signed [POS_W-1:0] vext(input logic signed [VEL_W-1:0] v);
    return {{(POS_W-VEL_W){v[VEL_W-1]}}, v};
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PH_W-1:0]         ph_q, ph_d;
  logic signed [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic signed [VEL_W-1:0] vx_q, vx_d, vy_q, vy_d;
  logic [N_PLAYERS-1:0]    hit_q, hit_d;
  logic                    blue_q, blue_d, red_q, red_d;

  logic tick;
  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Hoop detection: hoops 0..2 form the top row, 3..5 the bottom row.
  logic [5:0] in_hoop;
  for (genvar h = 0; h < 6; h++) begin : g_hoop
    localparam logic signed [D_W-1:0] HX = D_W'(GOAL_XC + (h % 3 - 1) * GOAL_DX);
    localparam logic signed [D_W-1:0] HY = D_W'((h < 3) ? GOAL_TOP_Y : GOAL_BOT_Y);
    assign in_hoop[h] = (sq(sext_pos(x_q) - HX) + sq(sext_pos(y_q) - HY)) < GOAL_R2;
  end

  logic goal_top, goal_bot;
  assign goal_top = |in_hoop[2:0];
  assign goal_bot = |in_hoop[5:3];

  // Per-player contact geometry on the current (pre-move) position.
  logic [N_PLAYERS-1:0] contact, x_dom, dx_neg, dy_neg;
  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_player
    logic signed [D_W-1:0] dx, dy;
    assign dx         = sext_pos(x_q) - zext_pix(player_x[10*i +: 10]);
    assign dy         = sext_pos(y_q) - zext_pix(player_y[10*i +: 10]);
    assign contact[i] = (sq(dx) + sq(dy)) < CONTACT_R2;
    assign x_dom[i]   = mag_d(dx) >= mag_d(dy);
    assign dx_neg[i]  = dx[D_W-1];
    assign dy_neg[i]  = dy[D_W-1];
  end

  // Wall reflection: each axis independently, so corners flip both.
  logic signed [POS_W-1:0] wx, wy;
  logic signed [VEL_W-1:0] wvx, wvy;
  always_comb begin
    wx  = x_q;
    wy  = y_q;
    wvx = vx_q;
    wvy = vy_q;
    if (x_q <= X_LO) begin
      wx  = X_LO_IN;
      wvx = vmag(vx_q);
    end else if (x_q >= X_HI) begin
      wx  = X_HI_IN;
      wvx = -vmag(vx_q);
    end
    if (y_q <= Y_LO) begin
      wy  = Y_LO_IN;
      wvy = vmag(vy_q);
    end else if (y_q >= Y_HI) begin
      wy  = Y_HI_IN;
      wvy = -vmag(vy_q);
    end
  end

  // Player reflection: lowest-index contact only. A reflection is applied
  // only when the ball is heading toward the player on the dominant axis,
  // which stops it from oscillating while still overlapping a disc.
  logic                    found, reflect;
  logic [N_PLAYERS-1:0]    hit_vec;
  logic signed [VEL_W-1:0] pvx, pvy;
  always_comb begin
    found   = 1'b0;
    reflect = 1'b0;
    hit_vec = '0;
    pvx     = wvx;
    pvy     = wvy;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (!found && contact[i]) begin
        found = 1'b1;
        if (x_dom[i]) begin
          reflect = dx_neg[i] ? (!wvx[VEL_W-1] && (wvx != '0)) : wvx[VEL_W-1];
        end else begin
          reflect = dy_neg[i] ? (!wvy[VEL_W-1] && (wvy != '0)) : wvy[VEL_W-1];
        end
        if (reflect) begin
          hit_vec[i] = 1'b1;
          if (x_dom[i]) pvx = -wvx;
          else          pvy = -wvy;
          pvx = vbump(pvx);
          pvy = vbump(pvy);
        end
      end
    end
  end

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    ph_d    = ph_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    hit_d   = '0;
    blue_d  = 1'b0;
    red_d   = 1'b0;
    if (game_over) begin
      state_d = ST_IDLE;
      x_d     = SX;
      y_d     = SY;
      vx_d    = V_BASE;
      vy_d    = V_BASE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (game_initiated) begin
            state_d = ST_SERVE;
            ph_d    = '0;
          end
        end
        ST_SERVE: begin
          x_d = SX;
          y_d = SY;
          if (tick) begin
            if (ph_q == PH_W'(SERVE_DELAY - 1)) begin
              state_d = ST_PLAY;
              ph_d    = '0;
            end else begin
              ph_d = ph_q + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (tick) begin
            if (goal_top || goal_bot) begin
              // Ball freezes in the hoop; the serve velocity is fixed now.
              blue_d  = goal_top;
              red_d   = !goal_top;
              state_d = ST_SCORED;
              ph_d    = '0;
              vx_d    = vx_q[VEL_W-1] ? -V_BASE : V_BASE;
              vy_d    = goal_top ? V_BASE : -V_BASE;
            end else begin
              x_d   = wx + vext(pvx);
              y_d   = wy + vext(pvy);
              vx_d  = pvx;
              vy_d  = pvy;
              hit_d = hit_vec;
            end
          end
        end
        ST_SCORED: begin
          if (tick) begin
            if (ph_q == PH_W'(SCORE_HOLD - 1)) begin
              state_d = ST_SERVE;
              ph_d    = '0;
              x_d     = SX;
              y_d     = SY;
            end else begin
              ph_d = ph_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      x_q     <= SX;
      y_q     <= SY;
      vx_q    <= V_BASE;
      vy_q    <= V_BASE;
      hit_q   <= '0;
      blue_q  <= 1'b0;
      red_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      hit_q   <= hit_d;
      blue_q  <= blue_d;
      red_q   <= red_d;
    end
  end

  assign x_position       = x_q;
  assign y_position       = y_q;
  assign ball_state       = state_q;
  assign hit_player       = hit_q;
  assign blue_score_pulse = blue_q;
  assign red_score_pulse  = red_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
`timescale 1ns/1ps
module tb_ball_motion_engine;

  localparam int TD = 4;
  localparam int SD = 2;
  localparam int SH = 3;
  localparam int NP = 4;
  localparam int POS_W = 11;
  localparam int B = 2;
  localparam int SX = 400;
  localparam int SY = 275;
  localparam int NCYC = 20000;
  localparam int RST_AT = 9000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic game_initiated = 1'b0;
  logic game_over = 1'b0;
  logic [NP*10-1:0] player_x = '0;
  logic [NP*10-1:0] player_y = '0;
  logic signed [POS_W-1:0] x_position, y_position;
  logic [1:0] ball_state;
  logic [NP-1:0] hit_player;
  logic blue_score_pulse, red_score_pulse;

  always #5 clk = ~clk;

  ball_motion_engine #(
    .TICK_DIV(TD), .SERVE_DELAY(SD), .SCORE_HOLD(SH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .game_initiated(game_initiated), .game_over(game_over),
    .player_x(player_x), .player_y(player_y),
    .x_position(x_position), .y_position(y_position),
    .ball_state(ball_state), .hit_player(hit_player),
    .blue_score_pulse(blue_score_pulse), .red_score_pulse(red_score_pulse)
  );

  typedef struct {
    int cyc; int st; int x; int y; int hit; int blue; int red;
  } exp_t;

  exp_t sbq[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state (plain integers).
  int m_st, m_x, m_y, m_vx, m_vy, m_cnt, m_ph;
  int px[NP];
  int py[NP];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

`ifdef SPEEDUP_EN
  function automatic int bump(input int v);
    int m;
    m = iabs(v) + 1;
    if (m > 6) m = 6;
    return (v < 0) ? -m : m;
  endfunction
`endif

  task automatic model_reset();
    m_st = 0; m_x = SX; m_y = SY; m_vx = B; m_vy = B; m_cnt = 0; m_ph = 0;
  endtask

  task automatic play_tick(inout exp_t e);
    int nx, ny, nvx, nvy, dx, dy, hx, hy;
    bit scored, top, done, refl;
    scored = 0; top = 0;
    for (int h = 0; h < 6; h++) begin
      hx = 400 + (h % 3 - 1) * 100;
      hy = (h < 3) ? 100 : 450;
      dx = m_x - hx;
      dy = m_y - hy;
      if (dx * dx + dy * dy < 32 * 32) begin
        scored = 1;
        top = (h < 3);
      end
    end
    if (scored) begin
      if (top) e.blue = 1; else e.red = 1;
      m_st = 3; m_ph = 0;
      m_vx = (m_vx < 0) ? -B : B;
      m_vy = top ? B : -B;
    end else begin
      nx = m_x; ny = m_y; nvx = m_vx; nvy = m_vy;
      if (m_x <= 158) begin nx = 159; nvx = iabs(m_vx); end
      else if (m_x >= 652) begin nx = 651; nvx = -iabs(m_vx); end
      if (m_y <= 44) begin ny = 45; nvy = iabs(m_vy); end
      else if (m_y >= 502) begin ny = 501; nvy = -iabs(m_vy); end
      done = 0;
      for (int i = 0; i < NP; i++) begin
        dx = m_x - px[i];
        dy = m_y - py[i];
        if (!done && (dx * dx + dy * dy < 36 * 36)) begin
          done = 1;
          refl = 0;
          if (iabs(dx) >= iabs(dy)) begin
            if (nvx * ((dx >= 0) ? 1 : -1) < 0) begin nvx = -nvx; refl = 1; end
          end else begin
            if (nvy * ((dy >= 0) ? 1 : -1) < 0) begin nvy = -nvy; refl = 1; end
          end
          if (refl) begin
            e.hit = e.hit | (1 << i);
`ifdef SPEEDUP_EN
            nvx = bump(nvx);
            nvy = bump(nvy);
`endif
          end
        end
      end
      m_x = nx + nvx; m_y = ny + nvy; m_vx = nvx; m_vy = nvy;
    end
  endtask

  task automatic model_step(output exp_t e);
    bit tick;
    e.cyc = cyc + 1; e.hit = 0; e.blue = 0; e.red = 0;
    tick = (m_cnt == TD - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    if (game_over) begin
      m_st = 0; m_x = SX; m_y = SY; m_vx = B; m_vy = B;
    end else begin
      case (m_st)
        0: if (game_initiated) begin m_st = 1; m_ph = 0; end
        1: if (tick) begin
             m_ph++;
             if (m_ph == SD) begin m_st = 2; m_ph = 0; end
           end
        2: if (tick) play_tick(e);
        3: if (tick) begin
             m_ph++;
             if (m_ph == SH) begin m_st = 1; m_ph = 0; m_x = SX; m_y = SY; end
           end
        default: ;
      endcase
    end
    e.st = m_st; e.x = m_x; e.y = m_y;
  endtask

  task automatic check_out(input string name, input exp_t e);
    n_cmp++;
    if (int'(ball_state) != e.st || int'(x_position) != e.x || int'(y_position) != e.y ||
        int'(hit_player) != e.hit || int'(blue_score_pulse) != e.blue ||
        int'(red_score_pulse) != e.red) begin
      n_mis++;
      $display("FAIL %s cyc=%0d: got st=%0d x=%0d y=%0d hit=%0h blue=%0d red=%0d, expected st=%0d x=%0d y=%0d hit=%0h blue=%0d red=%0d",
               name, cyc, ball_state, x_position, y_position, hit_player, blue_score_pulse,
               red_score_pulse, e.st, e.x, e.y, e.hit, e.blue, e.red);
    end
  endtask

  task automatic check_reset(input string name);
    exp_t r;
    r.cyc = cyc; r.st = 0; r.x = SX; r.y = SY; r.hit = 0; r.blue = 0; r.red = 0;
    check_out(name, r);
  endtask

  task automatic new_players();
    int r;
    for (int i = 0; i < NP; i++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        px[i] = m_x + int'($urandom_range(0, 80)) - 40;
        py[i] = m_y + int'($urandom_range(0, 80)) - 40;
      end else if (r < 4) begin
        px[i] = int'($urandom_range(0, 100));
        py[i] = int'($urandom_range(900, 1023));
      end else begin
        px[i] = int'($urandom_range(150, 660));
        py[i] = int'($urandom_range(36, 510));
      end
      if (px[i] < 0) px[i] = 0;
      if (px[i] > 1023) px[i] = 1023;
      if (py[i] < 0) py[i] = 0;
      if (py[i] > 1023) py[i] = 1023;
      player_x[10*i +: 10] = 10'(px[i]);
      player_y[10*i +: 10] = 10'(py[i]);
    end
  endtask

  // Monitor: compares DUT outputs against the expectation queued for this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        check_out("outputs", e);
      end
    end
  end

  // Driver: random stimulus, model step, expectation push.
  initial begin
    exp_t e;
    for (int i = 0; i < NP; i++) begin px[i] = 0; py[i] = 1000; end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_initial");
    rst_n = 1'b1;
    for (int k = 0; k < NCYC && n_mis < 20; k++) begin
      if (k == RST_AT) begin
        #4;
        rst_n = 1'b0;
        #1;
        check_reset("reset_async");
        sbq.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      if (k % 24 == 0) new_players();
      if ($urandom_range(0, 999) == 0) game_over = 1'b1;
      else if (game_over) game_over = ($urandom_range(0, 2) != 0);
      if (m_st == 0) game_initiated = ($urandom_range(0, 9) == 0);
      else           game_initiated = ($urandom_range(0, 1) == 1);
      model_step(e);
      sbq.push_back(e);
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #5;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
